// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions for the Q8.8 datapath stages.
// Provides the word geometry, the signed word type, the saturation limits,
// the value 1.0 and the state encoding of the sequential multiplier.
package fxp_pkg;

  localparam int Q_TOTAL_BITS = 16;
  localparam int Q_FRAC_BITS  = 8;

  typedef logic signed [Q_TOTAL_BITS-1:0] q_t;

  localparam q_t Q_MAX = 16'h7FFF;  // +127.99609375
  localparam q_t Q_MIN = 16'h8000;  // -128.0
  localparam q_t Q_ONE = 16'h0100;  // +1.0

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational rounding/saturation of an unsigned product magnitude back to
// a signed fixed-point word. Rounds to nearest with ties away from zero,
// saturates to the most positive / most negative word and flags it.
//   i_p    : unsigned magnitude, 2*TOTAL_BITS bits, 2*FRAC_BITS fractional bits
//   i_sign : 1 when the true result is negative
//   o_y    : signed result, TOTAL_BITS bits, FRAC_BITS fractional bits
//   o_ovf  : saturation was applied
module fxp_round_sat
  import fxp_pkg::*;
#(
  parameter int TOTAL_BITS = Q_TOTAL_BITS,
  parameter int FRAC_BITS  = Q_FRAC_BITS    // legal range 1..TOTAL_BITS-2
) (
  input  logic [2*TOTAL_BITS-1:0] i_p,
  input  logic                    i_sign,
  output logic [TOTAL_BITS-1:0]   o_y,
  output logic                    o_ovf
);

  // One spare bit so the rounding increment can never wrap.
  localparam int SW = 2*TOTAL_BITS + 1;
  localparam logic [SW-1:0] ONE     = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0] HALF    = ONE << (FRAC_BITS-1);
  localparam logic [SW-1:0] NEG_LIM = ONE << (TOTAL_BITS-1);   // |most negative|
  localparam logic [SW-1:0] POS_LIM = NEG_LIM - ONE;           // most positive

  logic [SW-1:0]         w_sum;
  logic [SW-1:0]         w_r;
  logic [TOTAL_BITS-1:0] w_mag;

  // NOTE: every output of a combinational block gets a default at the top so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_sum = {1'b0, i_p} + HALF;
    w_r   = w_sum >> FRAC_BITS;
    w_mag = w_r[TOTAL_BITS-1:0];
    o_y   = w_mag;
    o_ovf = 1'b0;
    if (!i_sign) begin
      if (w_r > POS_LIM) begin
        o_y   = {1'b0, {(TOTAL_BITS-1){1'b1}}};
        o_ovf = 1'b1;
      end
    end else if (w_r > NEG_LIM) begin
      o_y   = {1'b1, {(TOTAL_BITS-1){1'b0}}};
      o_ovf = 1'b1;
    end else begin
      // A magnitude of exactly 2^(TOTAL_BITS-1) negates to the most negative
      // word; a magnitude of zero stays zero.
      o_y = {TOTAL_BITS{1'b0}} - w_mag;
    end
  end

endmodule

// File: rtl/fxp_mul_seq.sv
// Sequential radix-2 shift-add multiplier for signed fixed-point operands.
// Multiplies magnitudes over TOTAL_BITS cycles, then rounds and saturates
// the product. Feeds one operand of the downstream fixed-point adder.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (a, b sampled on accept)
//   a, b                : signed operands
//   out_valid/out_ready : result handshake
//   y, ovf              : rounded/saturated product and saturation flag
module fxp_mul_seq
  import fxp_pkg::*;
#(
  parameter int TOTAL_BITS = Q_TOTAL_BITS,
  parameter int FRAC_BITS  = Q_FRAC_BITS    // legal range 1..TOTAL_BITS-2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TOTAL_BITS-1:0] a,
  input  logic [TOTAL_BITS-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TOTAL_BITS-1:0] y,
  output logic                  ovf
);

  localparam int MSB   = TOTAL_BITS - 1;
  localparam int CNT_W = $clog2(TOTAL_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL_BITS - 1);

  state_t r_state;
  state_t w_state_next;

  logic [2*TOTAL_BITS-1:0] r_acc;
  logic [2*TOTAL_BITS-1:0] r_mcand;
  logic [TOTAL_BITS-1:0]   r_mplr;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_sign;
  logic [TOTAL_BITS-1:0]   r_y;
  logic                    r_ovf;

  logic [TOTAL_BITS-1:0]   w_a_mag;
  logic [TOTAL_BITS-1:0]   w_b_mag;
  logic [2*TOTAL_BITS-1:0] w_acc_next;
  logic                    w_last;
  logic [TOTAL_BITS-1:0]   w_y;
  logic                    w_ovf;

  // Magnitudes fit unsigned in TOTAL_BITS, including the most negative value.
  assign w_a_mag = a[MSB] ? ({TOTAL_BITS{1'b0}} - a) : a;
  assign w_b_mag = b[MSB] ? ({TOTAL_BITS{1'b0}} - b) : b;

  assign w_acc_next = r_acc + (r_mplr[0] ? r_mcand : {(2*TOTAL_BITS){1'b0}});
  assign w_last     = (r_state == ST_BUSY) && (r_cnt == CNT_LAST);

  // The final partial product is folded in combinationally so the result
  // registers on the same edge as the last iteration.
  fxp_round_sat #(
    .TOTAL_BITS(TOTAL_BITS),
    .FRAC_BITS (FRAC_BITS)
  ) u_round_sat (
    .i_p   (w_acc_next),
    .i_sign(r_sign),
    .o_y   (w_y),
    .o_ovf (w_ovf)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous and wins over handshakes.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_state_next = ST_BUSY;
      ST_BUSY: if (w_last)    w_state_next = ST_DONE;
      ST_DONE: if (out_ready) w_state_next = ST_IDLE;
      default:                w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_cnt   <= '0;
      r_sign  <= 1'b0;
      r_y     <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_mcand <= {{TOTAL_BITS{1'b0}}, w_a_mag};
            r_mplr  <= w_b_mag;
            r_sign  <= a[MSB] ^ b[MSB];
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        ST_BUSY: begin
          r_acc   <= w_acc_next;
          r_mcand <= r_mcand << 1;
          r_mplr  <= r_mplr >> 1;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_y   <= w_y;
            r_ovf <= w_ovf;
          end
        end
        default: ;  // DONE holds y/ovf until the handshake
      endcase
    end
  end

  assign y   = r_y;
  assign ovf = r_ovf;

endmodule

// File: tb/tb_fxp_mul_seq.sv
// Directed testbench for fxp_mul_seq: hand-computed Q8.8 products, latency,
// backpressure, ignored operands while busy, back-to-back and mid-op reset.
module tb_fxp_mul_seq;
  import fxp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  fxp_mul_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present operands and hold in_valid until an accept edge has passed.
  task automatic start_op(input logic [15:0] va, input logic [15:0] vb);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    n        = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 16'hDEAD;
    b        = 16'hBEEF;
  endtask

  // Count rising edges after the accept edge until out_valid appears.
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 50);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".out_valid_after"}, out_valid, 0);
    check({tag, ".in_ready_after"}, in_ready, 1);
  endtask

  task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic [15:0] ey, input logic eovf, input int hold);
    int lat;
    start_op(va, vb);
    check({tag, ".in_ready_busy"}, in_ready, 0);
    wait_result(lat);
    check({tag, ".latency"}, lat, 16);
    check({tag, ".y"}, y, ey);
    check({tag, ".ovf"}, ovf, eovf);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, ".hold_valid"}, out_valid, 1);
      check({tag, ".hold_in_ready"}, in_ready, 0);
      check({tag, ".hold_y"}, y, ey);
      check({tag, ".hold_ovf"}, ovf, eovf);
    end
    handshake(tag);
  endtask

  initial begin
    int lat;
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.in_ready", in_ready, 1);
    check("reset.out_valid", out_valid, 0);
    check("reset.y", y, 0);
    check("reset.ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic, sign and rounding cases
    run_op("basic",     16'h0180, 16'h0200, 16'h0300, 1'b0, 0);
    run_op("mixed",     16'hFE80, 16'h0200, 16'hFD00, 1'b0, 0);
    run_op("zero_neg",  16'h0000, 16'h8000, 16'h0000, 1'b0, 0);
    run_op("rnd_half",  16'h0001, 16'h0080, 16'h0001, 1'b0, 0);
    run_op("rnd_nhalf", 16'hFFFF, 16'h0080, 16'hFFFF, 1'b0, 0);
    run_op("rnd_down",  16'h0001, 16'h007F, 16'h0000, 1'b0, 0);
    run_op("one",       Q_ONE,    Q_ONE,    16'h0100, 1'b0, 0);

    // Saturation boundaries
    run_op("sat_pos",   16'h6400, 16'h0200, 16'h7FFF, 1'b1, 0);
    run_op("sat_neg",   16'h9C00, 16'h0200, 16'h8000, 1'b1, 0);
    run_op("min_x_m1",  16'h8000, 16'hFF00, 16'h7FFF, 1'b1, 0);
    run_op("min_x_1",   16'h8000, 16'h0100, 16'h8000, 1'b0, 0);

    // Backpressure: result held for 5 cycles
    run_op("bp",        16'hFE80, 16'h0300, 16'hFB80, 1'b0, 5);

    // in_valid during BUSY must not launch a second operation
    start_op(16'h0180, 16'h0200);
    repeat (3) @(negedge clk);
    in_valid = 1'b1;
    a        = 16'h7FFF;
    b        = 16'h7FFF;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    wait_result(lat);
    check("poke.valid", out_valid, 1);
    check("poke.y", y, 16'h0300);
    check("poke.ovf", ovf, 0);
    handshake("poke");
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("poke.no_second", seen, 0);

    // Back-to-back: new operands offered during the output handshake
    start_op(16'h0100, 16'h0200);
    wait_result(lat);
    check("b2b.first_y", y, 16'h0200);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = 16'h0200;
    b         = 16'h0200;
    check("b2b.in_ready_done", in_ready, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("b2b.idle_valid", out_valid, 0);
    check("b2b.idle_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("b2b.accepted", in_ready, 0);
    wait_result(lat);
    check("b2b.latency", lat, 16);
    check("b2b.y", y, 16'h0400);
    check("b2b.ovf", ovf, 0);
    handshake("b2b");

    // Reset at BUSY cycle 7 discards the operation
    start_op(16'h0300, 16'h0300);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid.in_ready", in_ready, 1);
    check("rst_mid.out_valid", out_valid, 0);
    check("rst_mid.y", y, 0);
    check("rst_mid.ovf", ovf, 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("rst_mid.no_pulse", seen, 0);
    run_op("post_rst", 16'h0100, 16'h0100, 16'h0100, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
